// File: rtl/loader_pkg.sv
// Shared types for the loader-to-SDRAM write path: packed FIFO entry and output FSM states.
package loader_pkg;

  localparam int WORD_W         = 16;
  localparam int BE_W           = WORD_W / 8;
  // Word-address width carried in FIFO entries; ADDRESS_SIZE of the writer is LOADER_WADDR_W + 1.
  localparam int LOADER_WADDR_W = 24;

  typedef struct packed {
    logic [LOADER_WADDR_W-1:0] word_addr;
    logic [WORD_W-1:0]         data;
    logic [BE_W-1:0]           be;
  } wentry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_t;

endpackage

// File: rtl/loader_wfifo.sv
// First-word-fall-through FIFO of packed write entries; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module loader_wfifo
  import loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_memory,
  input  logic    reset,
  input  logic    push,
  input  wentry_t push_data,
  input  logic    pop,
  output wentry_t head,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  wentry_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_memory) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/loader_sdram_writer.sv
// Packs loader byte strobes into 16-bit SDRAM words, buffers them and issues req/ack writes.
// Optional LOADER_SDRAM_CHECKSUM_EN adds a running byte checksum (checksum, checksum_clear).
//
// state   | meaning
// ST_IDLE | no request outstanding; latch FIFO head when one is available
// ST_REQ  | sdram_req high, outputs frozen until sdram_ack
module loader_sdram_writer
  import loader_pkg::*;
#(
  parameter int ADDRESS_SIZE  = 25,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                    clk_memory,
  input  logic                    reset,
  input  logic                    in_wr,
  input  logic [ADDRESS_SIZE-1:0] in_addr,
  input  logic [7:0]              in_data,
  input  logic                    flush,
  output logic                    sdram_req,
  output logic [ADDRESS_SIZE-2:0] sdram_addr,
  output logic [WORD_W-1:0]       sdram_data,
  output logic [BE_W-1:0]         sdram_be,
  input  logic                    sdram_ack,
  output logic                    busy,
  output logic                    overflow
`ifdef LOADER_SDRAM_CHECKSUM_EN
  ,
  input  logic                    checksum_clear,
  output logic [31:0]             checksum
`endif
);

  localparam int TW = $clog2(FLUSH_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);

  wentry_t                   hold;
  wentry_t                   hold_nxt;
  logic                      hold_valid;
  logic                      valid_nxt;
  logic [TW-1:0]             tmo_cnt;
  logic [TW-1:0]             tmo_nxt;
  logic [LOADER_WADDR_W-1:0] waddr;
  logic                      hit;
  logic                      push;
  wentry_t                   push_entry;

  wentry_t                   fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      load;
  wr_state_t                 state;
  wr_state_t                 state_nxt;

  assign waddr = LOADER_WADDR_W'(in_addr[ADDRESS_SIZE-1:1]);
  assign hit   = hold_valid && (hold.word_addr == waddr);

  // Byte packing; a held even byte waiting for its odd partner is the only mergeable case.
  always_comb begin
    hold_nxt   = hold;
    valid_nxt  = hold_valid;
    push       = 1'b0;
    push_entry = hold;
    tmo_nxt    = '0;
    if (in_wr) begin
      if (!in_addr[0]) begin
        if (hit && hold.be == 2'b01) begin
          hold_nxt.data[7:0] = in_data;
        end else begin
          push      = hold_valid;
          hold_nxt  = '{word_addr: waddr, data: {8'h00, in_data}, be: 2'b01};
          valid_nxt = 1'b1;
        end
      end else begin
        if (hit && hold.be == 2'b01) begin
          push       = 1'b1;
          push_entry = '{word_addr: waddr, data: {in_data, hold.data[7:0]}, be: 2'b11};
          valid_nxt  = 1'b0;
        end else if (hit) begin
          hold_nxt.data[15:8] = in_data;
        end else begin
          push      = hold_valid;
          hold_nxt  = '{word_addr: waddr, data: {in_data, 8'h00}, be: 2'b10};
          valid_nxt = 1'b1;
        end
      end
    end else if (hold_valid) begin
      if (flush || tmo_cnt == TMO_LAST) begin
        push      = 1'b1;
        valid_nxt = 1'b0;
      end else begin
        tmo_nxt = tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      tmo_cnt    <= '0;
      overflow   <= 1'b0;
    end else begin
      hold       <= hold_nxt;
      hold_valid <= valid_nxt;
      tmo_cnt    <= tmo_nxt;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  loader_wfifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_wfifo (
    .clk_memory(clk_memory),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          pop       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The head stays in the FIFO until acked, so outputs are captured once per request.
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_be   <= '0;
    end else if (load) begin
      sdram_addr <= (ADDRESS_SIZE-1)'(fifo_head.word_addr);
      sdram_data <= fifo_head.data;
      sdram_be   <= fifo_head.be;
    end
  end

  assign sdram_req = (state == ST_REQ);
  assign busy      = hold_valid || !fifo_empty || sdram_req;

`ifdef LOADER_SDRAM_CHECKSUM_EN
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset)               checksum <= '0;
    else if (checksum_clear) checksum <= in_wr ? {24'h0, in_data} : 32'h0;
    else if (in_wr)          checksum <= checksum + {24'h0, in_data};
  end
`endif

endmodule

// File: doc/loader_sdram_writer.md
Name: loader_sdram_writer

Overview:
- Downstream of the Pocket data loader in the clk_memory domain.
- Consumes its byte-wide write strobes (write_en/write_addr/write_data, OUTPUT_WORD_SIZE=1) and packs even/odd byte pairs into 16-bit words with byte enables.
- Buffers packed words in a small FIFO and issues them to the SDRAM controller through a req/ack handshake, so slow SDRAM writes never drop loader data.

Parameters:
- ADDRESS_SIZE, 25, byte-address width of in_addr; the SDRAM word address is ADDRESS_SIZE-1 bits.
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, minimum 2.
- FLUSH_TIMEOUT, 16, idle clk_memory cycles before a half-filled word is flushed; minimum 2.

Ports:
- clk_memory  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- in_wr  in  1  one-cycle write strobe from the loader.
- in_addr  in  ADDRESS_SIZE  byte address.
- in_data  in  8  byte data.
- flush  in  1  one-cycle pulse; force out any held partial word.
- sdram_req  out  1  level request.
- sdram_addr  out  ADDRESS_SIZE-1  word address (in_addr[ADDRESS_SIZE-1:1]).
- sdram_data  out  16  little-endian: even byte in [7:0], odd byte in [15:8].
- sdram_be  out  2  byte enables; bit0 = even byte.
- sdram_ack  in  1  one-cycle pulse; current request accepted.
- busy  out  1  hold register valid OR FIFO non-empty OR sdram_req.
- overflow  out  1  sticky; a packed word was dropped because the FIFO was full.

Behaviour:
- Reset (async): all outputs are 0, the hold register is invalid, the FIFO is empty, the timeout counter is 0. Asserting reset mid-handshake drops sdram_req immediately; a late ack after reset is ignored.
- Hold register: {word_addr, data16, be2, valid}. At most one FIFO enqueue per cycle.
- in_wr, even address:
  - Enqueue the held word if valid.
  - Load the new byte into the hold register with be=01.
- in_wr, odd address, hold valid with matching word_addr: merge the byte into [15:8], enqueue with be=11, and invalidate hold in the same cycle.
- in_wr, odd address, no match:
  - Enqueue the held word if valid.
  - Load the new byte with be=10.
- A repeated write to the same byte in hold overwrites that byte; no enqueue.
- Flush triggers: flush pulse, or timeout counter reaching FLUSH_TIMEOUT-1 with hold valid and no in_wr. On either, enqueue hold and invalidate it.
  - The counter resets on any in_wr and counts only while hold is valid.
  - If in_wr and flush arrive in the same cycle, in_wr is processed and flush is ignored.
- FIFO full at enqueue: the entry is dropped and overflow is set. overflow clears only on reset.
- An enqueue and a dequeue in the same cycle on a full FIFO succeed.
- Output FSM, two states:
  - IDLE: when the FIFO is non-empty, present the head on sdram_addr/data/be, assert sdram_req next cycle, go to REQ.
  - REQ: outputs are held stable until sdram_ack. On ack: pop the head, deassert sdram_req next cycle, return to IDLE.
  - Minimum one idle cycle between requests.
  - An ack while in IDLE is ignored.
- Latency: paired odd write to sdram_req = 2 cycles, given an empty FIFO and IDLE state.
- busy falls only after the final ack and with the hold register empty.

Optional Feature:
- Macro LOADER_SDRAM_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0]: the modulo-2^32 sum of every in_data byte accepted on in_wr, updated the cycle after the strobe.
  - Adds input checksum_clear, which zeroes the sum; if clear and in_wr coincide, the sum becomes in_data.
  - Bytes dropped by overflow are still summed.
- Undefined: no checksum logic and no checksum ports.

Decomposition:
- Package loader_pkg:
  - typedef of the packed entry struct {word_addr, data, be}.
  - enum for the output FSM state {ST_IDLE, ST_REQ}.
  - localparam for the word width (16).
- Sub-module loader_wfifo: synchronous FIFO of entries with push/pop/full/empty, depth FIFO_DEPTH, async active-high reset, first-word-fall-through head output.

Test Plan:
- Paired bytes: in_wr at addr 0x10 data 0xAA, then addr 0x11 data 0xBB, ack 3 cycles after req → one request: addr 0x08, data 0xBBAA, be 11; busy falls after ack.
- Unpaired odd byte: addr 0x21 data 0x5C, no further writes → after FLUSH_TIMEOUT cycles, request addr 0x10, data[15:8]=0x5C, be 10.
- Non-matching sequence 0x00, 0x02, 0x03 → requests in order: (0x00, be 01), then (0x01, be 11, data {b3,b2}).
- Backpressure: ack withheld, 12 alternating paired writes (6 words) with FIFO_DEPTH 4 → overflow set; 4 words delivered in order once acks resume; sdram outputs stable while req held.
- Reset asserted while sdram_req high → req, busy, overflow go 0 asynchronously; a subsequent ack causes no FIFO pop and no new request.
- With LOADER_SDRAM_CHECKSUM_EN defined: bytes 0xFF,0x01,0x10 → checksum 0x110; checksum_clear coincident with a write of 0x07 → checksum 0x07.
